dmem_arbiter: RTL and testbench

//  Shares the single 256-bit data-memory port between two cache controllers:

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared 256-bit data-memory port: locked tenures,
// round-robin tie-break, one dead turnaround cycle between owners, and a sticky ack watchdog.
module dmem_arbiter #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         m0_enable_i,
    input  logic         m0_write_i,
    input  logic [31:0]  m0_addr_i,
    input  logic [255:0] m0_data_i,
    output logic [255:0] m0_data_o,
    output logic         m0_ack_o,
    input  logic         m1_enable_i,
    input  logic         m1_write_i,
    input  logic [31:0]  m1_addr_i,
    input  logic [255:0] m1_data_i,
    output logic [255:0] m1_data_o,
    output logic         m1_ack_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [1:0]   grant_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);
    localparam logic [TO_W-1:0] CNT_MAX  = '1;

    state_t          state_reg, state_next, arb_state;
    logic            last_owner_reg, last_owner_next;
    logic [TO_W-1:0] cnt_reg, cnt_next;
    logic            timeout_reg, timeout_next;
    logic [1:0]      grant;
    logic [1:0]      req_en;
    logic [1:0]      ack_vec;
    logic            owner_en;

    assign req_en = {m1_enable_i, m0_enable_i};
    assign grant  = (state_reg == OWN0) ? 2'b01 :
                    (state_reg == OWN1) ? 2'b10 : 2'b00;

    // Only the owner sees the memory ack; acks outside a tenure are dropped.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = grant[gi] & mem_ack_i;
        end
    endgenerate

    assign m0_ack_o  = ack_vec[0];
    assign m1_ack_o  = ack_vec[1];
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;
    assign grant_o   = grant;
    assign timeout_o = timeout_reg;

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        owner_en     = 1'b0;
        if (grant[0]) begin
            mem_enable_o = m0_enable_i;
            mem_write_o  = m0_write_i;
            mem_addr_o   = m0_addr_i;
            mem_data_o   = m0_data_i;
            owner_en     = m0_enable_i;
        end else if (grant[1]) begin
            mem_enable_o = m1_enable_i;
            mem_write_o  = m1_write_i;
            mem_addr_o   = m1_addr_i;
            mem_data_o   = m1_data_i;
            owner_en     = m1_enable_i;
        end
    end

    // On a tie the requester that did not own the bus last wins.
    always_comb begin
        arb_state = IDLE;
        case (req_en)
            2'b01:   arb_state = OWN0;
            2'b10:   arb_state = OWN1;
            2'b11:   arb_state = last_owner_reg ? OWN0 : OWN1;
            default: arb_state = IDLE;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = '0;
        timeout_next    = timeout_reg;
        case (state_reg)
            OWN0, OWN1: begin
                if (!owner_en) begin
                    state_next      = TURN;
                    last_owner_next = (state_reg == OWN1);
                end
                if (mem_ack_i) begin
                    cnt_next = '0;
                end else if (owner_en) begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                    if (cnt_next == TO_LIMIT) begin
                        timeout_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg;
                end
            end
            default: begin
                state_next = arb_state;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            cnt_reg        <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
            timeout_reg    <= timeout_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table run through an expected-value queue,
// plus a hand-written asynchronous reset in the middle of a tenure.
module tb_dmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         m0_enable_i = 0, m0_write_i = 0, m1_enable_i = 0, m1_write_i = 0;
    logic [31:0]  m0_addr_i = '0, m1_addr_i = '0;
    logic [255:0] m0_data_i = '0, m1_data_i = '0, mem_data_i = '0;
    logic         mem_ack_i = 0;
    logic [255:0] m0_data_o, m1_data_o, mem_data_o;
    logic         m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, timeout_o;
    logic [31:0]  mem_addr_o;
    logic [1:0]   grant_o;

    always #5 clk = ~clk;

    dmem_arbiter #(.TO_CYCLES(4), .TO_W(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    typedef struct {
        string       name;
        bit          rst;
        bit          e0, w0, e1, w1, ack;
        logic [31:0] a0addr, a1addr;
        logic [1:0]  g;
        bit          men, mwr, a0, a1, to;
    } vec_t;

    localparam logic [255:0] D0 = {8{32'hD0D0_0000}};
    localparam logic [255:0] D1 = {8{32'h1C1C_1111}};

    vec_t        vecs[$];
    vec_t        sb[$];
    int          total = 0;
    int          bad = 0;
    string       cur_sec;
    logic [31:0] cur_a0, cur_a1;

    function automatic void add(bit e0, bit w0, bit e1, bit w1, bit ack, logic [1:0] g,
                                bit men, bit mwr, bit a0, bit a1, bit to, bit rst = 0);
        vec_t v;
        v.name = $sformatf("%s[%0d]", cur_sec, vecs.size());
        v.rst = rst; v.e0 = e0; v.w0 = w0; v.e1 = e1; v.w1 = w1; v.ack = ack;
        v.a0addr = cur_a0; v.a1addr = cur_a1;
        v.g = g; v.men = men; v.mwr = mwr; v.a0 = a0; v.a1 = a1; v.to = to;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {grant_o, mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, timeout_o};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b0;
        m0_enable_i = 0; m1_enable_i = 0; m0_write_i = 0; m1_write_i = 0;
        mem_ack_i = 1'b1;
        #1;
        check("reset_ctl", 256'(ctl()), 256'd0);
        check("reset_addr", 256'(mem_addr_o), 256'd0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        rst_i = 1'b1;
    endtask

    task automatic reset_mid_tenure();
        do_reset();
        m1_addr_i = 32'h0000_5000;
        @(negedge clk);
        m1_enable_i = 1'b1;
        @(negedge clk);
        mem_data_i = {8{$urandom}};
        #1;
        check("mid_grant", 256'(grant_o), 256'd2);
        check("mid_men", 256'(mem_enable_o), 256'd1);
        check("mid_wdata", mem_data_o, D1);
        check("mid_rdata0", m0_data_o, mem_data_i);
        check("mid_rdata1", m1_data_o, mem_data_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_grant", 256'(grant_o), 256'd0);
        check("async_men", 256'(mem_enable_o), 256'd0);
        $display("reset mid-tenure: grant=%b men=%b", grant_o, mem_enable_o);
        @(negedge clk);
        rst_i = 1'b1;
        m0_enable_i = 1'b1;
        m1_enable_i = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_tie", 256'(grant_o), 256'd1);
        $display("post-reset tie: grant=%b", grant_o);
        m0_enable_i = 1'b0;
        m1_enable_i = 1'b0;
    endtask

    initial begin
        vec_t        v, e;
        logic [31:0] exp_addr;
        logic [255:0] exp_wd, rd;
        bit          own;

        m0_data_i = D0;
        m1_data_i = D1;

        // Simultaneous requests, m0 wins first tie, late ack, then m1 served.
        cur_sec = "simul"; cur_a0 = 32'h0000_1000; cur_a1 = 32'h0000_2000;
        add(1,0,1,0,0, 2'b00, 0,0,0,0,0, 1);
        repeat (4) add(1,0,1,0,0, 2'b01, 1,0,0,0,0);
        repeat (5) add(1,0,1,0,0, 2'b01, 1,0,0,0,1);
        add(1,0,1,0,1, 2'b01, 1,0,1,0,1);
        add(0,0,1,0,0, 2'b01, 0,0,0,0,1);
        add(0,0,1,1,0, 2'b00, 0,0,0,0,1);
        add(0,0,1,1,0, 2'b10, 1,1,0,0,1);
        add(0,0,1,1,1, 2'b10, 1,1,0,1,1);
        add(0,0,0,0,0, 2'b10, 0,0,0,0,1);
        add(0,0,0,0,0, 2'b00, 0,0,0,0,1);

        // Write-back then refill inside one locked dcache tenure.
        cur_sec = "wbrf"; cur_a0 = 32'h0000_0400; cur_a1 = 32'h0000_3000;
        add(1,1,1,0,0, 2'b00, 0,0,0,0,0, 1);
        add(1,1,1,0,0, 2'b01, 1,1,0,0,0);
        add(1,1,1,0,1, 2'b01, 1,1,1,0,0);
        cur_a0 = 32'h0001_0400;
        add(1,0,1,0,0, 2'b01, 1,0,0,0,0);
        add(1,0,1,0,1, 2'b01, 1,0,1,0,0);
        add(0,0,1,0,0, 2'b01, 0,0,0,0,0);
        add(0,0,1,0,0, 2'b00, 0,0,0,0,0);
        add(0,0,0,0,0, 2'b10, 0,0,0,0,0);
        add(0,0,0,0,0, 2'b00, 0,0,0,0,0);

        // Round-robin over six tenures with immediate re-requests.
        cur_sec = "rr"; cur_a0 = 32'h0000_0020; cur_a1 = 32'h0000_0040;
        add(1,0,1,0,0, 2'b00, 0,0,0,0,0, 1);
        for (int k = 0; k < 6; k++) begin
            own = k[0];
            add(1,0,1,0,1, own ? 2'b10 : 2'b01, 1,0,!own,own,0);
            add(own,0,!own,0,0, own ? 2'b10 : 2'b01, 0,0,0,0,0);
            add(k < 5,0,k < 5,0,0, 2'b00, 0,0,0,0,0);
        end

        // Spurious acks in IDLE and TURN; ack coinciding with release.
        cur_sec = "spur"; cur_a0 = 32'h0000_0060; cur_a1 = 32'h0000_0080;
        add(0,0,0,0,1, 2'b00, 0,0,0,0,0, 1);
        add(0,0,0,0,1, 2'b00, 0,0,0,0,0);
        add(0,0,1,0,0, 2'b00, 0,0,0,0,0);
        add(0,0,1,0,0, 2'b10, 1,0,0,0,0);
        add(0,0,0,0,0, 2'b10, 0,0,0,0,0);
        add(0,0,0,0,1, 2'b00, 0,0,0,0,0);
        add(0,0,0,0,0, 2'b00, 0,0,0,0,0);
        add(1,0,0,0,0, 2'b00, 0,0,0,0,0);
        add(1,0,0,0,0, 2'b01, 1,0,0,0,0);
        add(0,0,0,0,1, 2'b01, 0,0,1,0,0);
        add(0,0,0,0,1, 2'b00, 0,0,0,0,0);
        add(0,0,0,0,0, 2'b00, 0,0,0,0,0);

        // Watchdog with no ack: flag rises four cycles after the grant and sticks.
        cur_sec = "wdog"; cur_a0 = 32'h0000_00A0; cur_a1 = 32'h0000_00C0;
        add(0,0,1,0,0, 2'b00, 0,0,0,0,0, 1);
        repeat (4) add(0,0,1,0,0, 2'b10, 1,0,0,0,0);
        repeat (2) add(0,0,1,0,0, 2'b10, 1,0,0,0,1);
        add(0,0,0,0,0, 2'b10, 0,0,0,0,1);
        add(0,0,0,0,0, 2'b00, 0,0,0,0,1);

        // Watchdog with an ack in the third granted cycle: count restarts.
        cur_sec = "wdack";
        add(0,0,1,0,0, 2'b00, 0,0,0,0,0, 1);
        repeat (2) add(0,0,1,0,0, 2'b10, 1,0,0,0,0);
        add(0,0,1,0,1, 2'b10, 1,0,0,1,0);
        repeat (3) add(0,0,1,0,0, 2'b10, 1,0,0,0,0);
        add(0,0,0,0,0, 2'b10, 0,0,0,0,0);
        add(0,0,0,0,0, 2'b00, 0,0,0,0,0);

        reset_mid_tenure();

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.rst) do_reset();
            @(negedge clk);
            m0_enable_i = v.e0; m0_write_i = v.w0; m0_addr_i = v.a0addr;
            m1_enable_i = v.e1; m1_write_i = v.w1; m1_addr_i = v.a1addr;
            mem_ack_i = v.ack;
            rd = {8{$urandom}};
            mem_data_i = rd;
            sb.push_back(v);
            #1;
            e = sb.pop_front();
            exp_addr = (e.g == 2'b01) ? e.a0addr : (e.g == 2'b10) ? e.a1addr : 32'd0;
            exp_wd   = (e.g == 2'b01) ? D0 : (e.g == 2'b10) ? D1 : '0;
            check({e.name, ".ctl"}, 256'(ctl()),
                  256'({e.g, e.men, e.mwr, e.a0, e.a1, e.to}));
            check({e.name, ".addr"}, 256'(mem_addr_o), 256'(exp_addr));
            check({e.name, ".wdata"}, mem_data_o, exp_wd);
            check({e.name, ".rdata"}, m0_data_o ^ m1_data_o ^ rd, rd);
            $display("%s en=%b%b ack=%b grant=%b men=%b mwr=%b acks=%b%b to=%b addr=%h",
                     e.name, v.e0, v.e1, v.ack, grant_o, mem_enable_o, mem_write_o,
                     m0_ack_o, m1_ack_o, timeout_o, mem_addr_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
